// File: rtl/cpu_clock_reset.sv
// Divides the pixel clock into the 65C02 cpu_clk and sequences sys_rst / cpu_rst_B.
// Also provides a glitch-free debug halt and single-step that parks cpu_clk low.
module cpu_clock_reset #(
    parameter int unsigned CPU_CLK_DIV      = 4,
    parameter int unsigned RESET_CPU_CYCLES = 16
) (
    input  logic clk_12_5875,
    input  logic rst,
    input  logic halt_req,
    input  logic step,
    output logic cpu_clk,
    output logic cpu_clk_rise,
    output logic cpu_clk_fall,
    output logic sys_rst,
    output logic cpu_rst_B,
    output logic halted
);

    localparam int unsigned CW = $clog2(CPU_CLK_DIV);
    localparam int unsigned RW = $clog2(RESET_CPU_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CPU_CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CPU_CLK_DIV / 2);
    localparam logic [RW-1:0] RCNT_MAX  = RW'(RESET_CPU_CYCLES);
    localparam logic [RW-1:0] RCNT_HALF = RW'(RESET_CPU_CYCLES / 2);

    typedef enum logic [2:0] {
        RESET_HOLD,
        RUN,
        HALTING,
        HALTED,
        STEP
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next, cnt_inc;
    logic [RW-1:0]   rcnt, rcnt_next;
    logic            advance;
    logic            clk_next, rise_next, fall_next;
    logic            sys_rst_next, cpu_rst_b_next, halted_next;

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            state        <= RESET_HOLD;
            cnt          <= '0;
            rcnt         <= '0;
            cpu_clk      <= 1'b0;
            cpu_clk_rise <= 1'b0;
            cpu_clk_fall <= 1'b0;
            sys_rst      <= 1'b1;
            cpu_rst_B    <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            rcnt         <= rcnt_next;
            cpu_clk      <= clk_next;
            cpu_clk_rise <= rise_next;
            cpu_clk_fall <= fall_next;
            sys_rst      <= sys_rst_next;
            cpu_rst_B    <= cpu_rst_b_next;
            halted       <= halted_next;
        end
    end

    always_comb begin
        state_next     = state;
        rcnt_next      = rcnt;
        sys_rst_next   = sys_rst;
        cpu_rst_b_next = cpu_rst_B;
        halted_next    = halted;

        // Only HALTED freezes the phase; every state change happens with cnt
        // landing on 0, so no phase is ever shortened.
        advance   = (state != HALTED);
        cnt_inc   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        cnt_next  = advance ? cnt_inc : '0;
        clk_next  = advance && (cnt_inc >= CNT_HALF);
        rise_next = advance && (cnt_inc == CNT_HALF);
        fall_next = advance && (cnt_inc == '0);

        unique case (state)
            RESET_HOLD: begin
                if (rise_next && (rcnt != RCNT_MAX)) begin
                    rcnt_next = rcnt + 1'b1;
                end
                if (rcnt_next >= RCNT_HALF) begin
                    sys_rst_next = 1'b0;
                end
                if ((rcnt == RCNT_MAX) && fall_next) begin
                    cpu_rst_b_next = 1'b1;
                    state_next     = RUN;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_next = HALTING;
                end
            end
            HALTING: begin
                if (!halt_req) begin
                    state_next = RUN;
                end else if (fall_next) begin
                    state_next  = HALTED;
                    halted_next = 1'b1;
                end
            end
            HALTED: begin
                if (!halt_req) begin
                    state_next  = RUN;
                    halted_next = 1'b0;
                end else if (step) begin
                    state_next  = STEP;
                    halted_next = 1'b0;
                end
            end
            STEP: begin
                if (fall_next) begin
                    state_next  = HALTED;
                    halted_next = 1'b1;
                end
            end
            default: begin
                state_next = RESET_HOLD;
            end
        endcase
    end

endmodule

// File: doc/cpu_clock_reset.md
# cpu_clock_reset

Clock and reset sequencer that sits directly upstream of the console top level. It divides the 12.5875 MHz pixel clock into the 65C02 `cpu_clk` that the top level and controller interface consume. It sequences the system reset (`sys_rst` to the top level, `cpu_rst_B` to the CPU) and provides a debug halt / single-step facility that freezes `cpu_clk` low without glitches.

## Interface
- `CPU_CLK_DIV`, default 4: `cpu_clk` period in `clk_12_5875` cycles; even, ≥ 2 (4 gives ≈ 3.147 MHz).
- `RESET_CPU_CYCLES`, default 16: number of `cpu_clk` rising edges during which `cpu_rst_B` is held low; even, ≥ 2.
- `clk_12_5875`, in, 1: sole clock. Every register is clocked on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `halt_req`, in, 1: level. Requests that `cpu_clk` stop low.
- `step`, in, 1: one-cycle pulse. Runs one `cpu_clk` period while halted.
- `cpu_clk`, out, 1: registered divided clock, 50% duty.
- `cpu_clk_rise`, out, 1: one-cycle strobe, high in the cycle where `cpu_clk` first reads 1.
- `cpu_clk_fall`, out, 1: one-cycle strobe, high in the cycle where `cpu_clk` first reads 0.
- `sys_rst`, out, 1: active-high reset to the top level (GPU and related logic).
- `cpu_rst_B`, out, 1: active-low reset to the 65C02.
- `halted`, out, 1: high while the clock is frozen.

## Operation
- Phase counter `cnt` has width `$clog2(CPU_CLK_DIV)` and counts 0..DIV-1, then wraps to 0.
  - When running: `cnt ← (cnt+1) mod DIV` and `cpu_clk ← ((cnt+1) mod DIV) ≥ DIV/2`.
  - `cpu_clk` is low for cnt 0..DIV/2-1 and high for DIV/2..DIV-1.
- Rising-edge counter `rcnt` saturates at `RESET_CPU_CYCLES`.
- States: `RESET_HOLD`, `RUN`, `HALTING`, `HALTED`, `STEP`.
- `RESET_HOLD`:
  - The clock runs, because the 65C02 needs clocks during reset. `rcnt` increments on each rise.
  - `sys_rst` deasserts on the edge where `rcnt` reaches `RESET_CPU_CYCLES/2`.
  - On the first fall after `rcnt` reaches `RESET_CPU_CYCLES`: `cpu_rst_B` ← 1 and the state goes to `RUN`.
  - `halt_req` and `step` are ignored.
- `RUN`:
  - The clock runs freely.
  - `halt_req`=1 → `HALTING`.
  - `step` is ignored.
- `HALTING`:
  - The clock continues to run.
  - On the edge that sets `cnt` to 0 (a fall): go to `HALTED` and set `halted` ← 1 on the same edge.
  - If `halt_req` drops before that edge: return to `RUN`. There is no clock disturbance.
- `HALTED`:
  - `cnt` is frozen at 0 and `cpu_clk` stays 0. No strobes are generated.
  - `halt_req`=0 → `RUN`, with `halted` ← 0. Counting resumes on the next edge.
  - Otherwise, `step`=1 → `STEP`, with `halted` ← 0.
  - If `halt_req` drops in the same cycle as `step`, resume (`RUN`) wins and the step is dropped.
- `STEP`:
  - Runs exactly one full period: DIV/2 cycles low, then DIV/2 cycles high.
  - On the edge that sets `cnt` back to 0: return to `HALTED` and set `halted` ← 1.
  - `step` pulses arriving during `STEP` are ignored.
- Minimum phase widths: every low and high phase of `cpu_clk` lasts ≥ DIV/2 source cycles under all transitions. There are no runt pulses.
- `rst` asserted in any state, mid-period or mid-step: all registers return to reset values on that edge.

## Timing
- Reset values: `cnt`=0, `rcnt`=0, `cpu_clk`=0, `cpu_clk_rise`=0, `cpu_clk_fall`=0, `sys_rst`=1, `cpu_rst_B`=0, `halted`=0, state=`RESET_HOLD`.
- With DIV=4, edges counted after the last reset edge (edge 1 is the first edge with `rst`=0):
  - Edge 1: cnt=1.
  - Edge 2: cnt=2, `cpu_clk`=1, `cpu_clk_rise`=1.
  - Edge 4: cnt=0, `cpu_clk`=0, `cpu_clk_fall`=1.
  - Rise n occurs at edge 2+4(n-1).
- With defaults:
  - `sys_rst` falls on edge 30 (rise 8).
  - `cpu_rst_B` rises on edge 64, the fall after rise 16, coincident with `cpu_clk_fall`.
- Halt latency: from `halt_req` seen in `RUN` to `halted`=1 is ≤ DIV cycles, ending at the next fall.
- Resume latency: `cpu_clk` rises DIV/2 edges after the edge that leaves `HALTED`.
- Step: `cpu_clk_rise` occurs DIV/2 edges after the `step` edge. `cpu_clk_fall` and `halted`=1 occur DIV edges after it.

## Test plan
- Reset release with defaults:
  - `cpu_clk` period is 4 cycles with 2 high and 2 low.
  - `sys_rst` falls at edge 30.
  - `cpu_rst_B` rises at edge 64, aligned with `cpu_clk_fall`.
  - Strobes are exactly one cycle wide.
- Hold `halt_req`=1 from reset:
  - Nothing happens until `cpu_rst_B`=1.
  - `halted` rises ≤ 4 cycles later, with `cpu_clk`=0 and no strobes for 50 cycles.
- While `HALTED`, pulse `step` 3 times, 10 cycles apart:
  - Exactly 3 `cpu_clk_rise` and 3 `cpu_clk_fall` strobes, each rise 2 edges after its pulse.
  - `halted` returns to 1 after each step.
- `HALTED`, `step`=1 and `halt_req`→0 in the same cycle: state goes to `RUN`. The first rise comes 2 edges later and there is no extra stepped period.
- Pulse `halt_req` for 1 cycle in `RUN` while cnt=2: `cpu_clk` is unchanged and `halted` stays 0.
- Assert `rst` mid-`STEP` and mid-`RESET_HOLD`: all outputs return to reset values on that edge, and the full reset sequence repeats.
- Repeat the reset-release check with DIV=2: period is 2 cycles and `cpu_rst_B` rises at edge 32.
